// File: rtl/xcorr_pkg.sv
`default_nettype none
//============================================================================
// Module : xcorr_pkg
// Purpose: Shared definitions for the cross-correlation peak finder:
//          FSM state encoding, default frame geometry and the lag-offset
//          constant that maps a result index onto a signed lag.
// Revision: 1.0 - initial release
//============================================================================
package xcorr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    localparam int C_NLAG_DEFAULT       = 1023;
    localparam int C_LW_DEFAULT         = 11;
    // Index of the zero-lag result for the default frame length.
    localparam int C_LAG_OFFSET_DEFAULT = (C_NLAG_DEFAULT - 1) / 2;

    // Zero-lag index for an arbitrary (odd) frame length.
    function automatic int lag_offset(input int nlag);
        return (nlag - 1) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xcorr_peak_cmp.sv
`default_nettype none
//============================================================================
// Module : xcorr_peak_cmp
// Purpose: Combinational comparison of an incoming correlation sample
//          against the running best, plus the threshold test on whichever
//          of the two wins.
// Config : XCORR_PEAK_ABS_EN - compare magnitudes (RW+1 bits) instead of
//          signed values.
// Ports  : sample  - incoming signed correlation value
//          best    - current best signed value
//          thresh  - signed detection threshold
//          first   - sample is the first of the frame (always taken)
//          take    - sample replaces best (strictly greater)
//          ok      - winner meets the threshold
// Revision: 1.0 - initial release
//============================================================================
module xcorr_peak_cmp #(
    parameter int RW = 32
) (
    input  logic signed [RW-1:0] sample,
    input  logic signed [RW-1:0] best,
    input  logic signed [RW-1:0] thresh,
    input  logic                 first,
    output logic                 take,
    output logic                 ok
);

`ifdef XCORR_PEAK_ABS_EN
    // One extra bit so |most negative| is represented exactly.
    logic signed [RW:0] w_ext_s;
    logic signed [RW:0] w_ext_b;
    logic signed [RW:0] w_mag_s;
    logic signed [RW:0] w_mag_b;
    logic signed [RW:0] w_mag_win;
    logic signed [RW:0] w_thresh_x;

    always_comb begin
        w_ext_s    = $signed({sample[RW-1], sample});
        w_ext_b    = $signed({best[RW-1], best});
        w_thresh_x = $signed({thresh[RW-1], thresh});
        w_mag_s    = sample[RW-1] ? -w_ext_s : w_ext_s;
        w_mag_b    = best[RW-1]   ? -w_ext_b : w_ext_b;
        // The initial "most negative" best has the largest magnitude, so the
        // first sample of a frame must be taken unconditionally.
        take       = first | (w_mag_s > w_mag_b);
        w_mag_win  = take ? w_mag_s : w_mag_b;
        ok         = (w_mag_win >= w_thresh_x);
    end
`else
    logic signed [RW-1:0] w_win;

    always_comb begin
        take  = first | (sample > best);
        w_win = take ? sample : best;
        ok    = (w_win >= thresh);
    end
`endif

endmodule
`default_nettype wire

// File: rtl/xcorr_peak_find.sv
`default_nettype none
//============================================================================
// Module : xcorr_peak_find
// Purpose: Scans one frame of NLAG cross-correlation results, tracks the
//          first-occurring maximum and reports its signed lag, its value and
//          whether it reaches the detection threshold.
// Config : XCORR_PEAK_ABS_EN - search on |res_data| (see xcorr_peak_cmp).
// Ports  : clk, rst_n (async, active-low)
//          start     - frame start pulse (restarts a frame in progress)
//          res_valid - result strobe, res_data - signed result
//          min_peak  - signed detection threshold
//          peak_lag/peak_val/peak_ok - held results of the last frame
//          done      - one-cycle pulse when results update
//          busy      - high while collecting/reporting
//          err       - one-cycle pulse on restart or stray strobe
// Revision: 1.0 - initial release
//============================================================================
module xcorr_peak_find
    import xcorr_pkg::*;
#(
    parameter int RW   = 32,
    parameter int NLAG = C_NLAG_DEFAULT,
    parameter int LW   = C_LW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 res_valid,
    input  logic signed [RW-1:0] res_data,
    input  logic signed [RW-1:0] min_peak,
    output logic signed [LW-1:0] peak_lag,
    output logic signed [RW-1:0] peak_val,
    output logic                 peak_ok,
    output logic                 done,
    output logic                 busy,
    output logic                 err
);

    localparam logic [LW-1:0] C_LAST     = LW'(NLAG - 1);
    localparam logic [LW-1:0] C_OFFSET   = LW'(lag_offset(NLAG));
    localparam logic [RW-1:0] C_MOST_NEG = {1'b1, {(RW-1){1'b0}}};

    state_t                r_state;
    logic [LW-1:0]         r_idx;
    logic signed [RW-1:0]  r_best;
    logic [LW-1:0]         r_best_idx;

    logic                  w_restart;
    logic [LW-1:0]         w_idx_cur;
    logic signed [RW-1:0]  w_best_cur;
    logic [LW-1:0]         w_best_idx_cur;
    logic                  w_first;
    logic                  w_take;
    logic                  w_ok;
    logic signed [RW-1:0]  w_win_val;
    logic [LW-1:0]         w_win_idx;

    // A restart in COLLECT takes effect before any sample in the same cycle,
    // so the comparison sees a freshly cleared tracker.
    always_comb begin
        w_restart      = (r_state == ST_COLLECT) && start;
        w_idx_cur      = w_restart ? '0 : r_idx;
        w_best_cur     = w_restart ? $signed(C_MOST_NEG) : r_best;
        w_best_idx_cur = w_restart ? '0 : r_best_idx;
        w_first        = (w_idx_cur == '0);
        w_win_val      = w_take ? res_data  : w_best_cur;
        w_win_idx      = w_take ? w_idx_cur : w_best_idx_cur;
    end

    xcorr_peak_cmp #(
        .RW     (RW)
    ) u_cmp (
        .sample (res_data),
        .best   (w_best_cur),
        .thresh (min_peak),
        .first  (w_first),
        .take   (w_take),
        .ok     (w_ok)
    );

    // Results are captured at the edge that accepts the last strobe so that
    // they, together with done, are visible during the single REPORT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            peak_lag   <= '0;
            peak_val   <= '0;
            peak_ok    <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    err <= res_valid;
                    if (start) begin
                        r_state    <= ST_COLLECT;
                        busy       <= 1'b1;
                        r_idx      <= '0;
                        r_best     <= $signed(C_MOST_NEG);
                        r_best_idx <= '0;
                    end
                end
                ST_COLLECT: begin
                    err <= start;
                    if (res_valid) begin
                        r_idx      <= w_idx_cur + LW'(1);
                        r_best     <= w_win_val;
                        r_best_idx <= w_win_idx;
                        if (w_idx_cur == C_LAST) begin
                            r_state  <= ST_REPORT;
                            peak_lag <= w_win_idx - C_OFFSET;
                            peak_val <= w_win_val;
                            peak_ok  <= w_ok;
                            done     <= 1'b1;
                        end
                    end else if (w_restart) begin
                        r_idx      <= '0;
                        r_best     <= $signed(C_MOST_NEG);
                        r_best_idx <= '0;
                    end
                end
                ST_REPORT: begin
                    err     <= res_valid;
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
